// File: rtl/ram_arbiter.sv
// ram_arbiter: three-way arbiter in front of a single-port synchronous-read RAM.
//
// Requesters: bit0 = data port, bit1 = fetch port, bit2 = loader/debug port.
// A request is sampled in IDLE. At that edge the winner's we/addr/wdata are
// latched and ack_o pulses for one cycle. The RAM strobe is issued in ACCESS.
// A read then spends one cycle in RESP, where rvalid_o pulses and rdata_o
// carries ram_rdata_i.
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   req_i/we_i [2:0]       per-requester request / write enable
//   addr_i  [3*AW-1:0]     per-requester address, slice n = [n*AW +: AW]
//   wdata_i [3*DW-1:0]     per-requester write data, slice n = [n*DW +: DW]
//   ack_o    [2:0]         one-hot accept pulse
//   rvalid_o [2:0]         one-hot read-data-valid pulse
//   rdata_o  [DW-1:0]      shared read data, qualified by rvalid_o
//   ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o, ram_rdata_i   RAM port
//   busy_o                 state != IDLE
//
// Build option: define ARB_RR_EN for round-robin arbitration. The pointer
// resets to 2, so requester 0 is first in line. Without ARB_RR_EN the
// arbitration is fixed priority, with bit0 > bit1 > bit2.
module ram_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2:0]      req_i,
  input  logic [2:0]      we_i,
  input  logic [3*AW-1:0] addr_i,
  input  logic [3*DW-1:0] wdata_i,
  output logic [2:0]      ack_o,
  output logic [2:0]      rvalid_o,
  output logic [DW-1:0]   rdata_o,
  output logic            ram_en_o,
  output logic            ram_we_o,
  output logic [AW-1:0]   ram_addr_o,
  output logic [DW-1:0]   ram_wdata_o,
  input  logic [DW-1:0]   ram_rdata_i,
  output logic            busy_o
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t     state;
  logic [1:0] win;
  logic [2:0] win_oh;

`ifdef ARB_RR_EN
  logic [1:0] rr_ptr;
  logic       found;
  int         idx;

  // Scan the requesters circularly, starting one past the last winner.
  always_comb begin
    win   = 2'd0;
    found = 1'b0;
    idx   = 0;
    for (int i = 1; i <= 3; i++) begin
      idx = (int'(rr_ptr) + i) % 3;
      if (!found && req_i[idx]) begin
        win   = 2'(idx);
        found = 1'b1;
      end
    end
  end
`else
  always_comb begin
    win = 2'd0;
    if (req_i[0])      win = 2'd0;
    else if (req_i[1]) win = 2'd1;
    else if (req_i[2]) win = 2'd2;
  end
`endif

  assign win_oh = 3'(3'b001 << win);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ack_o       <= '0;
      rvalid_o    <= '0;
      ram_en_o    <= 1'b0;
      ram_we_o    <= 1'b0;
      ram_addr_o  <= '0;
      ram_wdata_o <= '0;
`ifdef ARB_RR_EN
      rr_ptr      <= 2'd2;
`endif
    end else begin
      case (state)
        IDLE: begin
          rvalid_o <= '0;
          if (|req_i) begin
            state       <= ACCESS;
            ack_o       <= win_oh;
            ram_en_o    <= 1'b1;
            ram_we_o    <= we_i[win];
            ram_addr_o  <= addr_i[int'(win)*AW +: AW];
            ram_wdata_o <= wdata_i[int'(win)*DW +: DW];
`ifdef ARB_RR_EN
            rr_ptr      <= win;
`endif
          end
        end
        ACCESS: begin
          ack_o    <= '0;
          ram_en_o <= 1'b0;
          ram_we_o <= 1'b0;
          if (ram_we_o) begin
            state <= IDLE;
          end else begin
            // ack_o still holds the winner, so it becomes the rvalid pulse.
            state    <= RESP;
            rvalid_o <= ack_o;
          end
        end
        RESP: begin
          rvalid_o <= '0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The RAM delivers data one cycle after the strobe, which is the RESP
  // cycle. The data is passed through so that it lines up with rvalid_o.
  assign rdata_o = (state == RESP) ? ram_rdata_i : '0;
  assign busy_o  = (state != IDLE);

endmodule

// File: tb/tb_ram_arbiter.sv
module tb_ram_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [2:0]      req_i = '0;
  logic [2:0]      we_i = '0;
  logic [3*AW-1:0] addr_i = '0;
  logic [3*DW-1:0] wdata_i = '0;
  logic [2:0]      ack_o, rvalid_o;
  logic [DW-1:0]   rdata_o;
  logic            ram_en_o, ram_we_o;
  logic [AW-1:0]   ram_addr_o;
  logic [DW-1:0]   ram_wdata_o;
  logic [DW-1:0]   ram_rdata_i = '0;
  logic            busy_o;

  ram_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .ack_o(ack_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .ram_en_o(ram_en_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
    .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read RAM model
  logic [DW-1:0] mem [0:255];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + 32'(i);
    mem[8'h10] = 32'hDEAD_BEEF;
  end
  always @(posedge clk) begin
    if (ram_en_o) begin
      if (ram_we_o) mem[ram_addr_o[7:0]] <= ram_wdata_o;
      else          ram_rdata_i <= mem[ram_addr_o[7:0]];
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    logic [2:0]  oh;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wd;
    int          cy;
  } ack_t;
  typedef struct {
    logic [2:0]  oh;
    logic [31:0] data;
    int          cy;
  } rd_t;

  ack_t ackq[$];
  rd_t  rdq[$];
  ack_t a;
  rd_t  r;

  // Scoreboard monitor: sampled on the falling edge, away from DUT updates
  always @(negedge clk) begin
    if (!rst) begin
      if (ram_we_o && !ram_en_o) chk("we_without_en", ram_we_o, 1'b0);
      if (ack_o != 3'b000) begin
        if (ackq.size() == 0) chk("ack_unexpected", ack_o, 3'b000);
        else begin
          a = ackq.pop_front();
          chk("ack_onehot", ack_o, a.oh);
          chk("ack_cycle", cyc, a.cy);
          chk("ram_en", ram_en_o, 1'b1);
          chk("ram_addr", ram_addr_o, a.addr);
          chk("ram_we", ram_we_o, a.we);
          if (a.we) chk("ram_wdata", ram_wdata_o, a.wd);
        end
      end
      if (rvalid_o != 3'b000) begin
        if (rdq.size() == 0) chk("rvalid_unexpected", rvalid_o, 3'b000);
        else begin
          r = rdq.pop_front();
          chk("rvalid_onehot", rvalid_o, r.oh);
          chk("rvalid_cycle", cyc, r.cy);
          chk("rdata", rdata_o, r.data);
        end
      end
    end
  end

  task automatic wait_ack();
    bit got = 1'b0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk); #1;
      if (ack_o != 3'b000) got = 1'b1;
    end
    if (!got) chk("ack_timeout", 1'b0, 1'b1);
  endtask

  task automatic set_port(input int n, input logic we, input logic [31:0] ad,
                          input logic [31:0] wd);
    we_i[n]          = we;
    addr_i[n*AW +: AW] = ad;
    wdata_i[n*DW +: DW] = wd;
  endtask

  task automatic do_req(input int n, input logic we, input logic [31:0] ad,
                        input logic [31:0] wd, input logic [31:0] exp_rd);
    @(negedge clk);
    set_port(n, we, ad, wd);
    req_i = 3'(1 << n);
    ackq.push_back('{oh: 3'(1 << n), addr: ad, we: we, wd: wd, cy: cyc + 1});
    if (!we) rdq.push_back('{oh: 3'(1 << n), data: exp_rd, cy: cyc + 2});
    wait_ack();
    req_i = '0;
    if (we) begin
      @(negedge clk); #1;
      chk("busy_after_write", busy_o, 1'b0);
    end else begin
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  int order [4];

  initial begin
    // Reset state
    #12;
    chk("rst_ack", ack_o, 3'b000);
    chk("rst_rvalid", rvalid_o, 3'b000);
    chk("rst_en", ram_en_o, 1'b0);
    chk("rst_we", ram_we_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_addr", ram_addr_o, 32'h0);
    chk("rst_wdata", ram_wdata_o, 32'h0);
    chk("rst_rdata", rdata_o, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Single read by requester 1, then a write and a read-back
    do_req(1, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF);
    do_req(0, 1'b1, 32'h4, 32'h55AA, 32'h0);
    do_req(2, 1'b0, 32'h4, 32'h0, 32'h55AA);
    do_req(1, 1'b1, 32'h30, 32'hCAFE_F00D, 32'h0);
    do_req(0, 1'b0, 32'h30, 32'h0, 32'hCAFE_F00D);

    // All three requesters reading at once
    do_reset();
`ifdef ARB_RR_EN
    order = '{0, 1, 2, 0};
`else
    order = '{0, 0, 0, 1};
`endif
    @(negedge clk);
    for (int n = 0; n < 3; n++) set_port(n, 1'b0, 32'h20 + 32'(n), 32'h0);
    req_i = 3'b111;
    for (int g = 0; g < 4; g++) begin
      ackq.push_back('{oh: 3'(1 << order[g]), addr: 32'h20 + 32'(order[g]),
                       we: 1'b0, wd: 32'h0, cy: cyc + 1 + 3*g});
      rdq.push_back('{oh: 3'(1 << order[g]), data: 32'h1000_0020 + 32'(order[g]),
                      cy: cyc + 2 + 3*g});
    end
    for (int g = 0; g < 4; g++) begin
      wait_ack();
`ifndef ARB_RR_EN
      if (g == 2) req_i[0] = 1'b0;
`endif
    end
    req_i = '0;
    repeat (4) @(negedge clk);

    // Reset asserted during the ACCESS cycle of a read
    @(negedge clk);
    set_port(1, 1'b0, 32'h10, 32'h0);
    req_i = 3'b010;
    ackq.push_back('{oh: 3'b010, addr: 32'h10, we: 1'b0, wd: 32'h0, cy: cyc + 1});
    wait_ack();
    #1;
    rst = 1'b1;
    req_i = '0;
    #1;
    chk("abort_ack", ack_o, 3'b000);
    chk("abort_en", ram_en_o, 1'b0);
    chk("abort_rvalid", rvalid_o, 3'b000);
    chk("abort_busy", busy_o, 1'b0);
    chk("abort_addr", ram_addr_o, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    do_req(1, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF);

    repeat (3) @(negedge clk);
    chk("ackq_drained", 64'(ackq.size()), 64'd0);
    chk("rdq_drained", 64'(rdq.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
